// File: rtl/mux_sched_pkg.sv
// Shared definitions for the 8:1 mux round-robin scheduler: sizes, FSM states
// and the index-to-one-hot helper.
package mux_sched_pkg;

    localparam int N      = 8;
    localparam int SEL_W  = $clog2(N);
    localparam int HOLD_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } sched_state_e;

    function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux8_rr_scheduler_rr_pick.sv
// Combinational round-robin pick: first set request bit strictly after `last`,
// scanning upward and wrapping, with `last` itself examined last.
module rr_pick
    import mux_sched_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        // Walk from the farthest distance down so the nearest hit wins.
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(last) + k) % N]) begin
                idx   = SEL_W'((int'(last) + k) % N);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux8_rr_scheduler.sv
// Round-robin owner scheduler for a shared 8:1 mux; bounds each ownership
// period to MAX_HOLD cycles whenever another requester is waiting.
module mux8_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    output logic [N-1:0]      grant,
    output logic [SEL_W-1:0]  sel,
    output logic              valid,
    output logic [HOLD_W-1:0] hold_cnt
);

    sched_state_e      state_q, state_d;
    logic [SEL_W-1:0]  last_q, last_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [N-1:0]      grant_q, grant_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic [SEL_W-1:0]  pick_last;
    logic [SEL_W-1:0]  pick_idx;
    logic              pick_found;
    logic              others_pending;
    logic              keep;

    // While owning, the scan starts after the current owner, which is exactly
    // the pointer value a release would install.
    assign pick_last = (state_q == OWN) ? sel_q : last_q;

    rr_pick u_pick (
        .req   (req),
        .last  (pick_last),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign others_pending = |(req & ~onehot(sel_q));
    assign keep = req[sel_q] && ((hold_q < HOLD_W'(MAX_HOLD)) || !others_pending);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (pick_found) begin
                    grant_d = onehot(pick_idx);
                    sel_d   = pick_idx;
                    hold_d  = HOLD_W'(1);
                    state_d = OWN;
                end
            end
            OWN: begin
                if (keep) begin
                    if (hold_q < HOLD_W'(MAX_HOLD)) begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end else begin
                    last_d = sel_q;
                    if (pick_found) begin
                        grant_d = onehot(pick_idx);
                        sel_d   = pick_idx;
                        hold_d  = HOLD_W'(1);
                    end else begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= SEL_W'(N - 1);
            sel_q   <= '0;
            grant_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
        end
    end

    assign grant    = grant_q;
    assign sel      = sel_q;
    assign valid    = |grant_q;
    assign hold_cnt = hold_q;

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Self-checking bench for mux8_rr_scheduler: directed scenarios plus random
// request traffic compared against a rotation-order reference model.
module tb_mux8_rr_scheduler;

    localparam int MAXH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] req = '0;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       valid;
    logic [3:0] hold_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state: owner index (-1 when idle), cycles held, pointer.
    int m_owner;
    int m_held;
    int m_last;
    int m_sel;

    mux8_rr_scheduler #(.MAX_HOLD(MAXH)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .grant    (grant),
        .sel      (sel),
        .valid    (valid),
        .hold_cnt (hold_cnt)
    );

    always #5 clk = ~clk;

    function automatic int next_after(input int p, input logic [7:0] r);
        for (int d = 1; d <= 8; d++) begin
            if (r[(p + d) % 8]) return (p + d) % 8;
        end
        return -1;
    endfunction

    function automatic logic [7:0] m_grant();
        logic [7:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = 7;
        m_sel   = 0;
    endtask

    task automatic model_step(input logic [7:0] r);
        int  p;
        bit  others;
        if (m_owner < 0) begin
            p = next_after(m_last, r);
            if (p >= 0) begin
                m_owner = p; m_sel = p; m_held = 1;
            end
        end else begin
            others = (r & ~(8'd1 << m_owner)) != 8'd0;
            if (r[m_owner] && (m_held < MAXH || !others)) begin
                if (m_held < MAXH) m_held++;
            end else begin
                m_last = m_owner;
                p = next_after(m_owner, r);
                if (p >= 0) begin
                    m_owner = p; m_sel = p; m_held = 1;
                end else begin
                    m_owner = -1;
                end
            end
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled at negedge.
    task automatic cycle();
        @(posedge clk);
        if (!rst) model_step(req);
        @(negedge clk);
    endtask

    task automatic do_reset();
        req = '0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (grant !== 8'h00) begin bad++; $display("FAIL reset_grant got=%h want=00", grant); end
        total++; if (sel !== 3'd0) begin bad++; $display("FAIL reset_sel got=%0d want=0", sel); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
        total++; if (hold_cnt !== 4'd0) begin bad++; $display("FAIL reset_hold got=%0d want=0", hold_cnt); end
    endtask

    task automatic test_single();
        do_reset();
        req = 8'b0000_0100;
        cycle();
        total++; if (grant !== 8'h04 || sel !== 3'd2 || valid !== 1'b1)
            begin bad++; $display("FAIL single_first got g=%h s=%0d v=%b want g=04 s=2 v=1", grant, sel, valid); end
        for (int i = 0; i < 8; i++) begin
            cycle();
            total++; if (grant !== 8'h04 || hold_cnt !== 4'((i + 2 > MAXH) ? MAXH : i + 2))
                begin bad++; $display("FAIL single_hold[%0d] got g=%h h=%0d", i, grant, hold_cnt); end
        end
    endtask

    task automatic test_fairness();
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 33; k++) begin
            cycle();
            total++; if (valid !== 1'b1 || sel !== 3'((k / MAXH) % 8) || grant !== (8'd1 << ((k / MAXH) % 8)))
                begin bad++; $display("FAIL fair[%0d] got s=%0d g=%h v=%b want s=%0d", k, sel, grant, valid, (k / MAXH) % 8); end
        end
    endtask

    task automatic test_early_release();
        do_reset();
        req = 8'h40;
        cycle();
        cycle();
        total++; if (sel !== 3'd6 || hold_cnt !== 4'd2) begin bad++; $display("FAIL early_own6 got s=%0d h=%0d want s=6 h=2", sel, hold_cnt); end
        req = 8'h82;
        cycle();
        total++; if (grant !== 8'h80 || sel !== 3'd7) begin bad++; $display("FAIL early_next got g=%h want g=80", grant); end
        req = 8'h02;
        cycle();
        total++; if (grant !== 8'h02 || sel !== 3'd1 || hold_cnt !== 4'd1) begin bad++; $display("FAIL early_wrap got g=%h s=%0d want g=02 s=1", grant, sel); end
    endtask

    task automatic test_simul_drop();
        do_reset();
        req = 8'h08;
        cycle();
        req = 8'h21;
        cycle();
        total++; if (grant !== 8'h20 || sel !== 3'd5) begin bad++; $display("FAIL simul got g=%h s=%0d want g=20 s=5", grant, sel); end
    endtask

    task automatic test_idle_hold();
        do_reset();
        req = 8'h10;
        cycle();
        req = 8'h00;
        cycle();
        total++; if (valid !== 1'b0 || grant !== 8'h00 || sel !== 3'd4)
            begin bad++; $display("FAIL idle got v=%b g=%h s=%0d want v=0 g=00 s=4", valid, grant, sel); end
        req = 8'h01;
        cycle();
        total++; if (grant !== 8'h01 || sel !== 3'd0 || valid !== 1'b1) begin bad++; $display("FAIL idle_regrant got g=%h s=%0d want g=01 s=0", grant, sel); end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 8'h20;
        cycle();
        cycle();
        total++; if (grant !== 8'h20) begin bad++; $display("FAIL async_pre got g=%h want 20", grant); end
        #2 rst = 1'b1;
        #1;
        total++; if (grant !== 8'h00 || valid !== 1'b0 || hold_cnt !== 4'd0)
            begin bad++; $display("FAIL async_clear got g=%h v=%b h=%0d want 00/0/0", grant, valid, hold_cnt); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        req = 8'hFF;
        cycle();
        total++; if (grant !== 8'h01 || sel !== 3'd0) begin bad++; $display("FAIL async_restart got g=%h s=%0d want g=01 s=0", grant, sel); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            cycle();
            total++; if (grant !== m_grant() || valid !== (m_owner >= 0) || sel !== 3'(m_sel))
                begin bad++; $display("FAIL rand[%0d] req=%h got g=%h s=%0d v=%b want g=%h s=%0d", i, req, grant, sel, valid, m_grant(), m_sel); end
            if (m_owner >= 0) begin
                total++; if (hold_cnt !== 4'(m_held)) begin bad++; $display("FAIL rand_hold[%0d] got=%0d want=%0d", i, hold_cnt, m_held); end
            end
            total++; if ((grant & (grant - 8'd1)) !== 8'h00) begin bad++; $display("FAIL rand_onehot[%0d] got g=%h want at most one bit", i, grant); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_fairness();
        test_early_release();
        test_simul_drop();
        test_idle_hold();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
